// File: rtl/soundrive.sv
// Soundrive 1.05 / Covox sample DAC front end: synchronizes Z80 OUT cycles into four
// 8-bit channel registers and fades them to zero after a period with no writes.
module soundrive #(
  parameter int unsigned IDLE_TIMEOUT = 4194304,
  parameter int unsigned FADE_DIV     = 4096
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       en_covox,
  input  logic       en_soundrive,
  input  logic [7:0] bus_a,
  input  logic [7:0] bus_d,
  input  logic       bus_iorq_n,
  input  logic       bus_wr_n,
  input  logic       bus_m1_n,
  output logic [7:0] sd_l0,
  output logic [7:0] sd_l1,
  output logic [7:0] sd_r0,
  output logic [7:0] sd_r1,
  output logic       wr_ack,
  output logic       fading
);

  localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int unsigned DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FADE_DIV - 1);

  typedef enum logic [1:0] {
    ST_SILENT,
    ST_ACTIVE,
    ST_FADE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        iorq_sync_q, wr_sync_q, m1_sync_q;
  logic              io_wr, io_wr_q, strobe_q;
  logic [7:0]        addr_q, data_q;
  logic [7:0]        ch_q   [4];
  logic [7:0]        ch_d   [4];
  logic [7:0]        ch_dec [4];
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              ack_q, ack_d;
  logic [3:0]        hit;
  logic              any_en;

  assign any_en = en_covox | en_soundrive;
  // An interrupt-acknowledge cycle (M1 low) also drives IORQ low and must not count.
  assign io_wr  = ~iorq_sync_q[1] & ~wr_sync_q[1] & m1_sync_q[1];

  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      iorq_sync_q <= 2'b11;
      wr_sync_q   <= 2'b11;
      m1_sync_q   <= 2'b11;
      io_wr_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      iorq_sync_q <= {iorq_sync_q[0], bus_iorq_n};
      wr_sync_q   <= {wr_sync_q[0], bus_wr_n};
      m1_sync_q   <= {m1_sync_q[0], bus_m1_n};
      io_wr_q     <= io_wr;
      strobe_q    <= io_wr & ~io_wr_q & any_en;
    end
  end

  // NOTE: address/data capture is pure datapath qualified by strobe_q, so it carries
  // no reset; only control state needs a defined value out of reset.
  always_ff @(posedge clk28) begin
    if (io_wr & ~io_wr_q) begin
      addr_q <= bus_a;
      data_q <= bus_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit = 4'b0000;
    if (strobe_q) begin
      if (addr_q == 8'hFB && en_covox) begin
        hit = 4'b1111;
      end else if (en_soundrive) begin
        case (addr_q)
          8'h0F:   hit = 4'b0001;
          8'h1F:   hit = 4'b0010;
          8'h4F:   hit = 4'b0100;
          8'h5F:   hit = 4'b1000;
          default: hit = 4'b0000;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_dec[i] = (ch_q[i] != 8'd0) ? ch_q[i] - 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    div_d   = div_q;
    ch_d    = ch_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        if (idle_q == IDLE_LAST) begin
          state_d = ST_FADE;
          idle_d  = '0;
          div_d   = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_FADE: begin
        if (div_q == DIV_LAST) begin
          ch_d  = ch_dec;
          div_d = '0;
          if ((ch_dec[0] | ch_dec[1] | ch_dec[2] | ch_dec[3]) == 8'd0) begin
            state_d = ST_SILENT;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        idle_d = '0;
        div_d  = '0;
      end
    endcase

    // A write cancels any fade step in the same cycle; untouched channels hold.
    if (hit != 4'b0000) begin
      ch_d = ch_q;
      for (int i = 0; i < 4; i++) begin
        if (hit[i]) ch_d[i] = data_q;
      end
      state_d = ST_ACTIVE;
      idle_d  = '0;
      div_d   = '0;
      ack_d   = 1'b1;
    end

    if (!any_en) begin
      for (int i = 0; i < 4; i++) ch_d[i] = 8'd0;
      state_d = ST_SILENT;
      idle_d  = '0;
      div_d   = '0;
      ack_d   = 1'b0;
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q <= ST_SILENT;
      idle_q  <= '0;
      div_q   <= '0;
      ch_q    <= '{default: 8'd0};
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      div_q   <= div_d;
      ch_q    <= ch_d;
      ack_q   <= ack_d;
    end
  end

  assign sd_l0  = ch_q[0];
  assign sd_l1  = ch_q[1];
  assign sd_r0  = ch_q[2];
  assign sd_r1  = ch_q[3];
  assign wr_ack = ack_q;
  assign fading = (state_q == ST_FADE);

endmodule

// File: tb/tb_soundrive.sv
// Bench for soundrive: directed scenarios with literal expectations plus a randomized
// CPU-cycle stream compared every cycle against a timestamp-based behavioural model.
module tb_soundrive;

  localparam int TO = 64;
  localparam int FD = 4;
  localparam int M_SILENT = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_FADE   = 2;

  logic       clk28 = 1'b0;
  logic       rst = 1'b1;
  logic       en_covox = 1'b0;
  logic       en_soundrive = 1'b0;
  logic [7:0] bus_a = 8'h00;
  logic [7:0] bus_d = 8'h00;
  logic       bus_iorq_n = 1'b1;
  logic       bus_wr_n = 1'b1;
  logic       bus_m1_n = 1'b1;
  logic [7:0] sd_l0, sd_l1, sd_r0, sd_r1;
  logic       wr_ack, fading;

  int n_checks = 0;
  int n_errors = 0;

  always #18 clk28 = ~clk28;

  soundrive #(.IDLE_TIMEOUT(TO), .FADE_DIV(FD)) dut (
    .clk28       (clk28),
    .rst         (rst),
    .en_covox    (en_covox),
    .en_soundrive(en_soundrive),
    .bus_a       (bus_a),
    .bus_d       (bus_d),
    .bus_iorq_n  (bus_iorq_n),
    .bus_wr_n    (bus_wr_n),
    .bus_m1_n    (bus_m1_n),
    .sd_l0       (sd_l0),
    .sd_l1       (sd_l1),
    .sd_r0       (sd_r0),
    .sd_r1       (sd_r1),
    .wr_ack      (wr_ack),
    .fading      (fading)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         due;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        pend[$];
  wr_t        m_w;
  int         m_ch[4] = '{0, 0, 0, 0};
  int         m_mode = M_SILENT;
  int         m_edge = 0;
  int         m_last = 0;
  int         m_fade0 = 0;
  bit         m_ack = 1'b0;
  bit         m_prev = 1'b0;
  bit         m_raw;
  logic [3:0] m_hit;

  function automatic logic [3:0] decode(input logic [7:0] a, input logic ec, input logic es);
    if (a == 8'hFB && ec) return 4'hF;
    if (es) begin
      if (a == 8'h0F) return 4'b0001;
      if (a == 8'h1F) return 4'b0010;
      if (a == 8'h4F) return 4'b0100;
      if (a == 8'h5F) return 4'b1000;
    end
    return 4'b0000;
  endfunction

  // A write cycle first seen at edge n lands on edge n+3 (4th edge counting n).
  initial forever begin
    @(posedge clk28 or posedge rst);
    if (rst) begin
      pend.delete();
      for (int i = 0; i < 4; i++) m_ch[i] = 0;
      m_mode = M_SILENT;
      m_ack  = 1'b0;
      m_prev = 1'b0;
    end else begin
      m_edge++;
      m_raw = !bus_iorq_n && !bus_wr_n && bus_m1_n;
      if (m_raw && !m_prev) pend.push_back('{due: m_edge + 3, a: bus_a, d: bus_d});
      m_prev = m_raw;
      m_ack  = 1'b0;
      m_hit  = 4'b0000;
      if (!en_covox && !en_soundrive) begin
        for (int i = 0; i < 4; i++) m_ch[i] = 0;
        m_mode = M_SILENT;
        pend.delete();
      end else begin
        if (pend.size() > 0 && pend[0].due == m_edge) begin
          m_w   = pend.pop_front();
          m_hit = decode(m_w.a, en_covox, en_soundrive);
        end
        if (m_hit != 4'b0000) begin
          for (int i = 0; i < 4; i++) if (m_hit[i]) m_ch[i] = int'(m_w.d);
          m_mode = M_ACTIVE;
          m_last = m_edge;
          m_ack  = 1'b1;
        end else if (m_mode == M_ACTIVE && m_edge - m_last == TO) begin
          m_mode  = M_FADE;
          m_fade0 = m_edge;
        end else if (m_mode == M_FADE && (m_edge - m_fade0) % FD == 0) begin
          for (int i = 0; i < 4; i++) if (m_ch[i] > 0) m_ch[i]--;
          if (m_ch[0] + m_ch[1] + m_ch[2] + m_ch[3] == 0) m_mode = M_SILENT;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk28);
    if (!rst) begin
      check("cmp_sd_l0", 32'(sd_l0), 32'(m_ch[0]));
      check("cmp_sd_l1", 32'(sd_l1), 32'(m_ch[1]));
      check("cmp_sd_r0", 32'(sd_r0), 32'(m_ch[2]));
      check("cmp_sd_r1", 32'(sd_r1), 32'(m_ch[3]));
      check("cmp_wr_ack", 32'(wr_ack), 32'(m_ack));
      check("cmp_fading", 32'(fading), 32'(m_mode == M_FADE));
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic bus_release();
    bus_iorq_n = 1'b1;
    bus_wr_n   = 1'b1;
    bus_m1_n   = 1'b1;
  endtask

  task automatic cpu_cycle(input logic [7:0] a, input logic [7:0] d, input logic wr_n,
                           input logic m1_n, input int len, input int gap);
    @(negedge clk28);
    bus_a      = a;
    bus_d      = d;
    bus_iorq_n = 1'b0;
    bus_wr_n   = wr_n;
    bus_m1_n   = m1_n;
    repeat (len) @(negedge clk28);
    bus_release();
    repeat (gap) @(negedge clk28);
  endtask

  task automatic wait_ack(output int k);
    k = 0;
    while (wr_ack !== 1'b1 && k < 10) begin
      @(posedge clk28); #1;
      k++;
    end
  endtask

  task automatic wait_fading(output int cnt);
    cnt = 0;
    while (fading !== 1'b1 && cnt < 200) begin
      @(posedge clk28); #1;
      cnt++;
      if (cnt == 4) bus_release();
    end
  endtask

  int k, cnt;
  logic [7:0] ra, rd;

  initial begin
    repeat (3) @(negedge clk28);
    rst = 1'b0;
    en_soundrive = 1'b1;
    @(posedge clk28); #1;
    check("reset_sd", {sd_l0, sd_l1, sd_r0, sd_r1}, 32'h0);
    check("reset_ack", 32'(wr_ack), 32'h0);
    check("reset_fading", 32'(fading), 32'h0);

    // Soundrive write to #4F with edge-exact latency
    @(negedge clk28);
    bus_a = 8'h4F; bus_d = 8'hC3; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    repeat (3) @(posedge clk28); #1;
    check("r0_before_edge4", 32'(sd_r0), 32'h0);
    check("ack_before_edge4", 32'(wr_ack), 32'h0);
    @(posedge clk28); #1;
    check("r0_on_edge4", 32'(sd_r0), 32'hC3);
    check("ack_on_edge4", 32'(wr_ack), 32'h1);
    check("others_untouched", {8'h00, sd_l0, sd_l1, sd_r1}, 32'h0);
    @(posedge clk28); #1;
    check("ack_one_cycle", 32'(wr_ack), 32'h0);
    repeat (6) @(negedge clk28);
    bus_release();
    repeat (4) @(negedge clk28);

    // Covox broadcast and enable gating
    en_covox = 1'b1;
    cpu_cycle(8'hFB, 8'h5A, 1'b0, 1'b1, 10, 4);
    check("covox_all", {sd_l0, sd_l1, sd_r0, sd_r1}, 32'h5A5A5A5A);
    en_covox = 1'b0;
    cpu_cycle(8'hFB, 8'h11, 1'b0, 1'b1, 10, 4);
    check("covox_disabled", {sd_l0, sd_l1, sd_r0, sd_r1}, 32'h5A5A5A5A);

    // Interrupt acknowledge: IORQ+M1 low, WR high
    cpu_cycle(8'h4F, 8'h22, 1'b1, 1'b0, 10, 4);
    check("intack_ignored", {sd_l0, sd_l1, sd_r0, sd_r1}, 32'h5A5A5A5A);

    // Both enables low clears everything on the next edge
    @(negedge clk28);
    en_covox = 1'b0; en_soundrive = 1'b0;
    @(posedge clk28); #1;
    check("disable_clears", {sd_l0, sd_l1, sd_r0, sd_r1}, 32'h0);
    @(negedge clk28);
    en_soundrive = 1'b1;

    // Fade of sd_l0 from 3
    @(negedge clk28);
    bus_a = 8'h0F; bus_d = 8'h03; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    wait_ack(k);
    check("l0_write_latency", 32'(k), 32'd4);
    wait_fading(cnt);
    check("fade_start_delay", 32'(cnt), 32'd64);
    for (int s = 2; s >= 0; s--) begin
      repeat (FD) @(posedge clk28); #1;
      check("fade_step", 32'(sd_l0), 32'(s));
    end
    check("fade_done_silent", 32'(fading), 32'h0);
    repeat (4) @(negedge clk28);

    // Write during fade
    @(negedge clk28);
    bus_a = 8'h0F; bus_d = 8'h03; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    wait_ack(k);
    wait_fading(cnt);
    repeat (FD) @(posedge clk28); #1;
    check("midfade_l0_is_2", 32'(sd_l0), 32'h2);
    bus_a = 8'h1F; bus_d = 8'h80; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    wait_ack(k);
    check("midfade_ack", 32'(wr_ack), 32'h1);
    check("midfade_l1", 32'(sd_l1), 32'h80);
    check("midfade_l0_held", 32'(sd_l0), 32'h2);
    check("midfade_fading_off", 32'(fading), 32'h0);
    wait_fading(cnt);
    check("midfade_idle_restart", 32'(cnt), 32'd64);

    // Asynchronous reset mid-strobe
    @(negedge clk28);
    bus_a = 8'h5F; bus_d = 8'h77; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    repeat (2) @(posedge clk28);
    #5 rst = 1'b1;
    #1;
    check("async_reset_sd", {sd_l0, sd_l1, sd_r0, sd_r1}, 32'h0);
    check("async_reset_fading", 32'(fading), 32'h0);
    bus_release();
    repeat (2) @(negedge clk28);
    rst = 1'b0;
    repeat (8) @(negedge clk28);
    check("no_spurious_after_reset", {sd_l0, sd_l1, sd_r0, sd_r1}, 32'h0);

    // Randomized CPU traffic
    for (int t = 0; t < 160; t++) begin
      if ($urandom_range(0, 99) < 8) begin
        @(negedge clk28);
        en_covox = 1'b0; en_soundrive = 1'b0;
        bus_a = 8'hFB; bus_d = 8'($urandom); bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
        repeat (3) @(negedge clk28);
        bus_release();
        repeat (5) @(negedge clk28);
        en_covox = 1'b1;
        en_soundrive = 1'($urandom_range(0, 1));
      end else begin
        en_covox = ($urandom_range(0, 3) != 0);
        en_soundrive = ($urandom_range(0, 3) != 0);
        if (!en_covox && !en_soundrive) en_soundrive = 1'b1;
        case ($urandom_range(0, 6))
          0: ra = 8'hFB;
          1: ra = 8'h0F;
          2: ra = 8'h1F;
          3: ra = 8'h4F;
          4: ra = 8'h5F;
          default: ra = 8'($urandom);
        endcase
        rd = 8'($urandom);
        cpu_cycle(ra, rd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0),
                  $urandom_range(1, 12),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(60, 200) : $urandom_range(4, 10));
      end
    end

    repeat (6) @(negedge clk28);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/soundrive.md
Name: soundrive

Overview:
- Z80 I/O-mapped 8-bit sample DAC front end (Soundrive 1.05 / Covox).
- Captures CPU OUT cycles into four 8-bit channel registers and drives them unsigned into the audio mixer's sd_l0/sd_l1/sd_r0/sd_r1 inputs.
- Has an idle-fade engine: after a period with no writes, it ramps each channel down to 0. This removes DC offset from the mixer sum without an audible click.

Parameters:
- IDLE_TIMEOUT, 4194304: clk28 cycles (~150 ms) with no accepted write before fading starts.
- FADE_DIV, 4096: clk28 cycles between successive fade decrement steps.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst  in  1  asynchronous reset, active-high
- en_covox  in  1  enable Covox port #FB
- en_soundrive  in  1  enable Soundrive ports #0F/#1F/#4F/#5F
- bus_a  in  8  CPU address low byte (asynchronous to clk28)
- bus_d  in  8  CPU data bus (asynchronous to clk28)
- bus_iorq_n  in  1  CPU IORQ, active-low (asynchronous to clk28)
- bus_wr_n  in  1  CPU WR, active-low (asynchronous to clk28)
- bus_m1_n  in  1  CPU M1, active-low (asynchronous to clk28); low marks an interrupt-acknowledge cycle
- sd_l0  out  8  left channel 0 sample, unsigned
- sd_l1  out  8  left channel 1 sample, unsigned
- sd_r0  out  8  right channel 0 sample, unsigned
- sd_r1  out  8  right channel 1 sample, unsigned
- wr_ack  out  1  one-cycle pulse on each accepted write
- fading  out  1  high while in FADE state

Behaviour:
- Reset (rst high, asynchronous): all sd_* = 0, wr_ack = 0, fading = 0, state = SILENT, idle counter = 0, synchronizers cleared to the inactive level (1).
- Synchronizing and strobe detection:
  - bus_iorq_n, bus_wr_n, bus_m1_n each pass through a 2-flop synchronizer.
  - io_wr = !iorq_s & !wr_s & m1_s.
  - A write strobe is the rising edge of io_wr, detected with one extra register.
  - bus_a and bus_d are sampled on the strobe cycle; they are stable by then because of the synchronizer delay.
- Decode, evaluated only on a strobe:
  - Address #FB with en_covox: all four channels <= bus_d.
  - Address #0F with en_soundrive: sd_l0 <= bus_d.
  - Address #1F with en_soundrive: sd_l1 <= bus_d.
  - Address #4F with en_soundrive: sd_r0 <= bus_d.
  - Address #5F with en_soundrive: sd_r1 <= bus_d.
  - Any other address, or the matching enable low: ignored. No wr_ack, no change to state or counter.
- Latency: sd_* and wr_ack update on the 4th clk28 rising edge after IORQ and WR are both low.
  - Edges 1-2: synchronizer.
  - Edge 3: edge detect.
  - Edge 4: output register.
  - wr_ack is high for exactly one cycle.
- Long or repeated strobes: one CPU cycle gives exactly one write, regardless of pulse length. A new write needs io_wr to deassert and reassert.
- State machine:
  - ACTIVE:
    - Idle counter increments every cycle and resets to 0 on any accepted write.
    - When the counter reaches IDLE_TIMEOUT-1: go to FADE and reset the fade divider.
  - FADE:
    - fading = 1.
    - Every FADE_DIV cycles, each nonzero channel decrements by 1 (saturating at 0, never wraps).
    - When all four channels are 0, go to SILENT.
  - SILENT:
    - Channels hold at 0 and the counter holds at 0.
    - An accepted write goes to ACTIVE.
- Write during FADE or SILENT:
  - The written channel(s) take bus_d exactly; this overrides any decrement in the same cycle.
  - Channels not addressed keep their current (partially faded) value.
  - State goes to ACTIVE and the idle counter resets to 0.
- Write of 0 to every channel while ACTIVE: stays ACTIVE until the timeout. FADE then completes on its first step check and goes to SILENT.
- Enables:
  - If en_covox and en_soundrive are both 0: next cycle all channels = 0, state = SILENT, any strobe in progress is discarded.
  - A single enable changing does not alter stored channel values.
- Counters: the idle counter is $clog2(IDLE_TIMEOUT) bits wide and the fade divider is $clog2(FADE_DIV) bits wide. Neither wraps; both reset on a state change.

Test Plan:
- Soundrive write: en_soundrive=1; OUT #4F,#C3 (IORQ/WR low for 10 cycles) -> sd_r0=#C3 on the 4th edge after assertion; wr_ack high for exactly 1 cycle; other channels unchanged at 0.
- Covox broadcast and enable gating:
  - en_covox=1, OUT #FB,#5A -> all four sd_* = #5A.
  - Repeat with en_covox=0 -> no change, no wr_ack.
- M1 qualification: IORQ+M1 low with WR high (interrupt ack) -> no write; glitch-free outputs.
- Fade, with IDLE_TIMEOUT=64 and FADE_DIV=4:
  - Write #03 to #0F, then idle -> fading rises 64 cycles after wr_ack.
  - sd_l0 steps 3->2->1->0 every 4 cycles.
  - fading drops and state is SILENT after the last step.
- Write mid-fade: during FADE with sd_l0=#02, OUT #1F,#80 -> sd_l1=#80, sd_l0 stays #02, fading=0, idle counter restarts.
- Reset and disable mid-operation:
  - Assert rst mid-strobe -> all outputs 0 immediately; after release, no spurious write.
  - Drop both enables -> all channels 0 the next cycle.
